// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: state encoding, per-boundary payload layouts and NOP payloads.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [2:0]  MemDisable  = 3'b000;
  localparam logic [31:0] ZeroMemAddr = 32'h0000_0000;
  localparam logic [3:0]  MemSelEmpty = 4'b0000;
  localparam logic        SEXT        = 1'b1;
  localparam logic        ZEXT        = 1'b0;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [2:0]  me_op;
    logic [31:0] me_addr;
    logic [31:0] me_data;
    logic [3:0]  me_sel;
    logic        me_extend;
  } exmem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
  } memwb_t;

  localparam int unsigned EXMEM_W = $bits(exmem_t);
  localparam int unsigned IFID_W  = $bits(ifid_t);
  localparam int unsigned MEMWB_W = $bits(memwb_t);

  localparam exmem_t EXMEM_NOP_S = '{
    wdata:     ZeroWord,
    wd:        NOPRegAddr,
    wreg:      WriteDisable,
    me_op:     MemDisable,
    me_addr:   ZeroMemAddr,
    me_data:   ZeroWord,
    me_sel:    MemSelEmpty,
    me_extend: SEXT
  };

  localparam logic [EXMEM_W-1:0] EXMEM_NOP = EXMEM_NOP_S;
  localparam logic [IFID_W-1:0]  IFID_NOP  = '0;
  localparam logic [MEMWB_W-1:0] MEMWB_NOP = '0;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Stage-to-stage handshake bundle: upstream valid/ready/data, downstream valid/ready/data and flush.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 110
) ();
  logic              flush;
  logic              up_valid;
  logic [DATA_W-1:0] up_data;
  logic              up_ready;
  logic              down_valid;
  logic [DATA_W-1:0] down_data;
  logic              down_ready;

  modport slave (
    input  flush, up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data
  );

  modport master (
    output flush, up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter; holds at all-ones, cleared only by asynchronous reset.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with two-entry skid buffer and synchronous flush.
// Optional perf counters (stall/bubble/flush) enabled by defining PIPE_PERF_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = EXMEM_W,
  parameter logic [DATA_W-1:0] NOP_VAL = EXMEM_NOP
`ifdef PIPE_PERF_EN
  ,parameter int unsigned      CNT_W   = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pipe_skid_reg_if.slave   bus
`ifdef PIPE_PERF_EN
  ,output logic [CNT_W-1:0] stall_cnt
  ,output logic [CNT_W-1:0] bubble_cnt
  ,output logic [CNT_W-1:0] flush_cnt
`endif
);

  pipe_state_e       state, state_n;
  logic [DATA_W-1:0] main_q, main_n;
  logic [DATA_W-1:0] skid_q, skid_n;
  logic              up_ready_q;
  logic              up_xfer, dn_xfer;

  assign bus.up_ready   = up_ready_q;
  assign bus.down_valid = (state != EMPTY);
  assign bus.down_data  = main_q;

  assign up_xfer = bus.up_valid & up_ready_q;
  assign dn_xfer = bus.down_valid & bus.down_ready;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    unique case (state)
      EMPTY: begin
        if (up_xfer) begin
          main_n  = bus.up_data;
          state_n = ONE;
        end
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_n = bus.up_data;
        end else if (dn_xfer) begin
          main_n  = NOP_VAL;
          state_n = EMPTY;
        end else if (up_xfer) begin
          skid_n  = bus.up_data;
          state_n = FULL;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          main_n  = skid_q;
          skid_n  = NOP_VAL;
          state_n = ONE;
        end
      end
      default: begin
        state_n = EMPTY;
        main_n  = NOP_VAL;
        skid_n  = NOP_VAL;
      end
    endcase
  end

  // Flush overrides the handshake result: the downstream transfer still
  // completes (main is simply cleared) and any accepted upstream entry is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      main_q     <= NOP_VAL;
      skid_q     <= NOP_VAL;
      up_ready_q <= 1'b0;
    end else if (bus.flush) begin
      state      <= EMPTY;
      main_q     <= NOP_VAL;
      skid_q     <= NOP_VAL;
      up_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      main_q     <= main_n;
      skid_q     <= skid_n;
      up_ready_q <= (state_n != FULL);
    end
  end

`ifdef PIPE_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.down_valid & ~bus.down_ready),
    .count (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~bus.down_valid),
    .count (bubble_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.flush),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (EX/MEM width, NOP payload = 110'h1).
module tb_pipe_skid_reg;
  localparam int unsigned DW = 110;
  localparam logic [DW-1:0] NOP = 110'h1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_skid_reg_if #(.DATA_W(DW)) bus ();

`ifdef PIPE_PERF_EN
  logic [1:0] stall_cnt, bubble_cnt, flush_cnt;
  pipe_skid_reg #(.DATA_W(DW), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );
`else
  pipe_skid_reg #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic dr, input logic fl);
    bus.up_valid   = v;
    bus.up_data    = d;
    bus.down_ready = dr;
    bus.flush      = fl;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d, input logic ur);
    check({tag, ".down_valid"}, 128'(v ? bus.down_valid : bus.down_valid), 128'(v));
    check({tag, ".down_data"}, 128'(bus.down_data), 128'(d));
    check({tag, ".up_ready"}, 128'(bus.up_ready), 128'(ur));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held two cycles with up_valid asserted
    rst = 1'b0;
    drive(1'b1, 110'h5, 1'b1, 1'b0);
    tick();
    tick();
    expect_out("reset", 1'b0, NOP, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("reset_release", 1'b0, NOP, 1'b1);

    // Streaming 0x1..0x8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, DW'(i), 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    expect_out("stream_drain", 1'b0, NOP, 1'b1);

    // Back-pressure after entry 0x3
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      tick();
    end
    expect_out("bp_head3", 1'b1, 110'h3, 1'b1);
    drive(1'b1, 110'h4, 1'b0, 1'b0);
    tick();
    expect_out("bp_full", 1'b1, 110'h3, 1'b0);
    drive(1'b1, 110'h5, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("bp_hold", 1'b1, 110'h3, 1'b0);
    drive(1'b1, 110'h5, 1'b1, 1'b0);
    tick();
    expect_out("bp_rel4", 1'b1, 110'h4, 1'b1);
    tick();
    expect_out("bp_rel5", 1'b1, 110'h5, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    expect_out("bp_drain", 1'b0, NOP, 1'b1);

    // Flush while FULL, upstream offering 0xA
    drive(1'b1, 110'h6, 1'b0, 1'b0);
    tick();
    drive(1'b1, 110'h7, 1'b0, 1'b0);
    tick();
    expect_out("fl_full", 1'b1, 110'h6, 1'b0);
    drive(1'b1, 110'hA, 1'b0, 1'b1);
    tick();
    expect_out("fl_full_after", 1'b0, NOP, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    expect_out("fl_no_A", 1'b0, NOP, 1'b1);

    // Flush in ONE with an accepted upstream entry: it is discarded
    drive(1'b1, 110'hB, 1'b1, 1'b0);
    tick();
    expect_out("fl_one_B", 1'b1, 110'hB, 1'b1);
    drive(1'b1, 110'hC, 1'b1, 1'b1);
    tick();
    expect_out("fl_one_after", 1'b0, NOP, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    expect_out("fl_no_C", 1'b0, NOP, 1'b1);

    // Asynchronous reset between edges
    drive(1'b1, 110'h11, 1'b0, 1'b0);
    tick();
    expect_out("ar_pre", 1'b1, 110'h11, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expect_out("ar_async", 1'b0, NOP, 1'b0);
`ifdef PIPE_PERF_EN
    check("perf_rst_stall", 128'(stall_cnt), 128'd0);
    check("perf_rst_bubble", 128'(bubble_cnt), 128'd0);
    check("perf_rst_flush", 128'(flush_cnt), 128'd0);
`endif
    tick();
    rst = 1'b1;
    drive(1'b1, 110'h12, 1'b1, 1'b0);
    tick();
    expect_out("ar_restart_rdy", 1'b0, NOP, 1'b1);
    tick();
    expect_out("ar_restart12", 1'b1, 110'h12, 1'b1);
    drive(1'b1, 110'h13, 1'b1, 1'b0);
    tick();
    expect_out("ar_restart13", 1'b1, 110'h13, 1'b1);

`ifdef PIPE_PERF_EN
    // Counters with CNT_W=2: saturate at 3
    rst = 1'b0;
    #1;
    rst = 1'b1;
    drive(1'b1, 110'h1, 1'b0, 1'b0);
    tick();
    tick();
    check("perf_bubble2", 128'(bubble_cnt), 128'd2);
    check("perf_stall0", 128'(stall_cnt), 128'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("perf_stall2", 128'(stall_cnt), 128'd2);
    tick();
    tick();
    check("perf_stall_sat", 128'(stall_cnt), 128'd3);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    check("perf_flush2", 128'(flush_cnt), 128'd2);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("perf_bubble_sat", 128'(bubble_cnt), 128'd3);
    check("perf_stall_final", 128'(stall_cnt), 128'd3);
    check("perf_flush_final", 128'(flush_cnt), 128'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
